// File: rtl/remainder_scheduler_pkg.sv
// Shared types and helpers for the remainder scheduler: FSM encoding and
// per-channel divider extraction from the packed divider bus.
package remainder_scheduler_pkg;

    localparam int unsigned SCHED_REM_WIDTH = 8;
    localparam int unsigned MAX_CHANNELS    = 16;
    localparam int unsigned MAX_REM_WIDTH   = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_WAIT   = 2'd2,
        S_NEXT   = 2'd3
    } sched_state_t;

    // Returns channel k's divider; the caller zero-extends its bus to the
    // maximum supported width and truncates the result to its own REM_WIDTH.
    function automatic logic [MAX_REM_WIDTH-1:0] channel_divider(
        input logic [MAX_CHANNELS*MAX_REM_WIDTH-1:0] vec,
        input int unsigned                           k,
        input int unsigned                           rem_w
    );
        logic [MAX_REM_WIDTH-1:0] mask;
        mask = {MAX_REM_WIDTH{1'b1}} >> (MAX_REM_WIDTH - rem_w);
        return MAX_REM_WIDTH'(vec >> (k * rem_w)) & mask;
    endfunction

endpackage

// File: rtl/remainder_scheduler.sv
// Time-shares one external long divider across N trigger channels, computing
// (pulse_id + 1) mod divider[k] for every enabled channel after each pulse-ID frame.
module remainder_scheduler
    import remainder_scheduler_pkg::*;
#(
    parameter int unsigned N_CHANNELS = 4,
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned REM_WIDTH  = SCHED_REM_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pulse_id_tick_i,
    input  logic [WIDTH-1:0]                pulse_id_i,
    input  logic [N_CHANNELS*REM_WIDTH-1:0] divider_i,
    input  logic [N_CHANNELS-1:0]           enable_i,
    output logic                            div_start_o,
    output logic [WIDTH-1:0]                div_a_o,
    output logic [WIDTH-1:0]                div_b_o,
    input  logic                            div_done_i,
    input  logic [WIDTH-1:0]                div_rem_i,
    output logic [N_CHANNELS*REM_WIDTH-1:0] rem_o,
    output logic [N_CHANNELS-1:0]           rem_valid_o,
    output logic                            busy_o,
    output logic                            overrun_o
);

    localparam int unsigned K_W   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int unsigned VEC_W = MAX_CHANNELS * MAX_REM_WIDTH;
    localparam logic [K_W-1:0] LAST_K = K_W'(N_CHANNELS - 1);

    sched_state_t                    state_q, state_d;
    logic [K_W-1:0]                  k_q, k_d;
    logic [WIDTH-1:0]                id_q, id_d;
    logic                            pending_q, pending_d;
    logic                            overrun_q, overrun_d;
    logic                            start_q, start_d;
    logic [WIDTH-1:0]                a_q, a_d;
    logic [WIDTH-1:0]                b_q, b_d;
    logic [N_CHANNELS*REM_WIDTH-1:0] rem_q, rem_d;
    logic [N_CHANNELS-1:0]           valid_q, valid_d;

    logic [REM_WIDTH-1:0] sel_div;
    logic                 tick_busy;

    assign sel_div   = REM_WIDTH'(channel_divider(VEC_W'(divider_i), 32'(k_q), REM_WIDTH));
    assign tick_busy = pulse_id_tick_i && (state_q != S_IDLE);

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        id_d      = id_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        start_d   = 1'b0;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        valid_d   = '0;

        if (pulse_id_tick_i) begin
            id_d = pulse_id_i + WIDTH'(1);
        end
        // A tick while busy never aborts the current channel; it queues a restart.
        if (tick_busy) begin
            overrun_d = 1'b1;
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pulse_id_tick_i) begin
                    k_d     = '0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!enable_i[k_q]) begin
                    state_d = S_NEXT;
                end else if (sel_div == '0) begin
                    rem_d[k_q*REM_WIDTH +: REM_WIDTH] = '0;
                    valid_d[k_q]                      = 1'b1;
                    state_d                           = S_NEXT;
                end else begin
                    a_d     = id_q;
                    b_d     = WIDTH'(sel_div);
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_done_i) begin
                    rem_d[k_q*REM_WIDTH +: REM_WIDTH] = REM_WIDTH'(div_rem_i);
                    valid_d[k_q]                      = 1'b1;
                    state_d                           = S_NEXT;
                end
            end
            S_NEXT: begin
                if (pending_q || pulse_id_tick_i) begin
                    k_d       = '0;
                    pending_d = 1'b0;
                    state_d   = S_SELECT;
                end else if (k_q == LAST_K) begin
                    state_d = S_IDLE;
                end else begin
                    k_d     = k_q + K_W'(1);
                    state_d = S_SELECT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            id_q      <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            start_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            start_q   <= start_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            valid_q   <= valid_d;
        end
    end

    assign div_start_o = start_q;
    assign div_a_o     = a_q;
    assign div_b_o     = b_q;
    assign rem_o       = rem_q;
    assign rem_valid_o = valid_q;
    assign busy_o      = (state_q != S_IDLE);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_remainder_scheduler.sv
// Directed bench for remainder_scheduler with a behavioural divider of configurable latency.
module tb_remainder_scheduler;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int RW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            pulse_id_tick_i;
    logic [W-1:0]    pulse_id_i;
    logic [N*RW-1:0] divider_i;
    logic [N-1:0]    enable_i;
    logic            div_start_o;
    logic [W-1:0]    div_a_o;
    logic [W-1:0]    div_b_o;
    logic            div_done_i;
    logic [W-1:0]    div_rem_i;
    logic [N*RW-1:0] rem_o;
    logic [N-1:0]    rem_valid_o;
    logic            busy_o;
    logic            overrun_o;

    logic         model_done, inject_done;
    logic [W-1:0] model_rem, inject_rem;
    int           div_lat;

    int n_checks = 0;
    int n_fail   = 0;

    int           start_cnt;
    logic [W-1:0] start_a[$];
    logic [W-1:0] start_b[$];
    int           vch[$];
    logic [RW-1:0] vrem[$];

    int           e_ch[$];
    logic [RW-1:0] e_rem[$];
    logic [W-1:0] e_a[$];

    assign div_done_i = model_done | inject_done;
    assign div_rem_i  = inject_done ? inject_rem : model_rem;

    remainder_scheduler #(.N_CHANNELS(N), .WIDTH(W), .REM_WIDTH(RW)) dut (
        .clk(clk), .reset(reset),
        .pulse_id_tick_i(pulse_id_tick_i), .pulse_id_i(pulse_id_i),
        .divider_i(divider_i), .enable_i(enable_i),
        .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_done_i(div_done_i), .div_rem_i(div_rem_i),
        .rem_o(rem_o), .rem_valid_o(rem_valid_o),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    // Divider model: done arrives div_lat cycles after the start pulse; upper
    // remainder bits carry junk that the scheduler must discard.
    initial begin
        int           cnt;
        logic [W-1:0] m_a, m_b;
        cnt = 0; m_a = '0; m_b = 64'd1;
        model_done = 1'b0; model_rem = '0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        model_done = 1'b1;
                        model_rem  = 64'hA5A5_A5A5_A5A5_A500 | (m_a % m_b);
                    end
                end
                if (div_start_o) begin
                    m_a = div_a_o;
                    m_b = div_b_o;
                    cnt = div_lat;
                end
            end
        end
    end

    initial begin
        start_cnt = 0;
        forever begin
            @(negedge clk);
            if (div_start_o) begin
                start_cnt++;
                start_a.push_back(div_a_o);
                start_b.push_back(div_b_o);
            end
            for (int k = 0; k < N; k++) begin
                if (rem_valid_o[k]) begin
                    vch.push_back(k);
                    vrem.push_back(rem_o[k*RW +: RW]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        start_cnt = 0;
        start_a.delete(); start_b.delete();
        vch.delete(); vrem.delete();
    endtask

    task automatic do_tick(input logic [W-1:0] id);
        @(negedge clk);
        pulse_id_tick_i = 1'b1;
        pulse_id_i      = id;
        @(negedge clk);
        pulse_id_tick_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_in_time"}, 64'(n < budget), 64'd1);
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_nvalid"}, 64'(vch.size()), 64'(e_ch.size()));
        for (int i = 0; i < e_ch.size(); i++) begin
            if (i < vch.size()) begin
                check($sformatf("%s_vch%0d", tag, i), 64'(vch[i]), 64'(e_ch[i]));
                check($sformatf("%s_vrem%0d", tag, i), 64'(vrem[i]), 64'(e_rem[i]));
            end
        end
        check({tag, "_nstart"}, 64'(start_a.size()), 64'(e_a.size()));
        for (int i = 0; i < e_a.size(); i++) begin
            if (i < start_a.size())
                check($sformatf("%s_a%0d", tag, i), start_a[i], e_a[i]);
        end
    endtask

    initial begin
        reset = 1'b1; pulse_id_tick_i = 1'b0; pulse_id_i = '0;
        divider_i = '0; enable_i = '0; div_lat = 3;
        inject_done = 1'b0; inject_rem = '0;
        repeat (3) @(negedge clk);
        check("rst_rem", 64'(rem_o), 64'd0);
        check("rst_valid", 64'(rem_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_overrun", 64'(overrun_o), 64'd0);
        check("rst_start", 64'(div_start_o), 64'd0);
        check("rst_a", div_a_o, 64'd0);
        check("rst_b", div_b_o, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic sequence: 100 mod {3,5,7,10} = {1,0,2,0}
        divider_i = {8'd10, 8'd7, 8'd5, 8'd3};
        enable_i  = 4'b1111;
        clear_logs();
        do_tick(64'd99);
        check("t1_busy_t1", 64'(busy_o), 64'd1);
        check("t1_start_t1", 64'(div_start_o), 64'd0);
        @(negedge clk);
        check("t1_start_t2", 64'(div_start_o), 64'd1);
        check("t1_a_t2", div_a_o, 64'd100);
        check("t1_b_t2", div_b_o, 64'd3);
        wait_idle("t1", 200);
        e_ch = {0, 1, 2, 3};
        e_rem = {8'd1, 8'd0, 8'd2, 8'd0};
        e_a = {64'd100, 64'd100, 64'd100, 64'd100};
        compare_logs("t1");
        check("t1_rem", 64'(rem_o), 64'h0002_0001);
        check("t1_overrun", 64'(overrun_o), 64'd0);

        // Skip ch2, zero divider on ch1: id 7 -> ch0=1, ch1=0, ch2 held, ch3=3
        divider_i = {8'd4, 8'd9, 8'd0, 8'd3};
        enable_i  = 4'b1011;
        clear_logs();
        do_tick(64'd6);
        wait_idle("t2", 200);
        e_ch = {0, 1, 3};
        e_rem = {8'd1, 8'd0, 8'd3};
        e_a = {64'd7, 64'd7};
        compare_logs("t2");
        check("t2_b0", start_b.size() > 0 ? start_b[0] : 64'd0, 64'd3);
        check("t2_b1", start_b.size() > 1 ? start_b[1] : 64'd0, 64'd4);
        check("t2_rem", 64'(rem_o), 64'h0302_0001);

        // Wrap-around: id all-ones + 1 = 0
        divider_i = {8'd0, 8'd0, 8'd0, 8'd7};
        enable_i  = 4'b0001;
        clear_logs();
        do_tick(64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("t3_start", 64'(div_start_o), 64'd1);
        check("t3_a", div_a_o, 64'd0);
        check("t3_b", div_b_o, 64'd7);
        wait_idle("t3", 200);
        e_ch = {0};
        e_rem = {8'd0};
        e_a = {64'd0};
        compare_logs("t3");
        check("t3_rem", 64'(rem_o), 64'h0302_0000);

        // Overrun: second tick during ch1's WAIT restarts at ch0 with id 21
        divider_i = {8'd10, 8'd7, 8'd4, 8'd3};
        enable_i  = 4'b1111;
        div_lat   = 65;
        clear_logs();
        do_tick(64'd10);
        wait_starts("t4", 2, 200);
        repeat (10) @(negedge clk);
        check("t4_busy_mid", 64'(busy_o), 64'd1);
        check("t4_overrun_before", 64'(overrun_o), 64'd0);
        do_tick(64'd20);
        check("t4_overrun_set", 64'(overrun_o), 64'd1);
        wait_idle("t4", 2000);
        e_ch = {0, 1, 0, 1, 2, 3};
        e_rem = {8'd2, 8'd3, 8'd0, 8'd1, 8'd0, 8'd1};
        e_a = {64'd11, 64'd11, 64'd21, 64'd21, 64'd21, 64'd21};
        compare_logs("t4");
        check("t4_rem", 64'(rem_o), 64'h0100_0100);
        check("t4_overrun_sticky", 64'(overrun_o), 64'd1);

        // Reset in the middle of a WAIT, then a stale done after release
        clear_logs();
        do_tick(64'd40);
        wait_starts("t5", 1, 200);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rst_busy", 64'(busy_o), 64'd0);
        check("t5_rst_rem", 64'(rem_o), 64'd0);
        check("t5_rst_overrun", 64'(overrun_o), 64'd0);
        check("t5_rst_a", div_a_o, 64'd0);
        check("t5_rst_b", div_b_o, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        clear_logs();
        inject_done = 1'b1;
        inject_rem  = 64'h55;
        @(negedge clk);
        inject_done = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_stale_rem", 64'(rem_o), 64'd0);
        check("t5_stale_valid", 64'(vch.size()), 64'd0);
        check("t5_stale_busy", 64'(busy_o), 64'd0);
        check("t5_stale_start", 64'(start_cnt), 64'd0);

        divider_i = {8'd10, 8'd7, 8'd5, 8'd3};
        div_lat   = 2;
        clear_logs();
        do_tick(64'd99);
        wait_idle("t5", 200);
        e_ch = {0, 1, 2, 3};
        e_rem = {8'd1, 8'd0, 8'd2, 8'd0};
        e_a = {64'd100, 64'd100, 64'd100, 64'd100};
        compare_logs("t5");
        check("t5_rem", 64'(rem_o), 64'h0002_0001);
        check("t5_overrun", 64'(overrun_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/remainder_scheduler.md
Name: remainder_scheduler

Overview:
- Shares one iterative 64-bit long-division unit between N trigger channels. Each channel has its own divider; the block computes (pulse_id + 1) mod divider for every channel after each pulse-ID frame.
- Sits between the frame receiver and the Trigger channels of one board. It replaces the per-channel divider instances.
- Sequences the divisions channel by channel, then presents one registered remainder per channel.

Parameters:
- N_CHANNELS, 4, number of trigger channels served (1..16)
- WIDTH, 64, pulse-ID and dividend width in bits
- REM_WIDTH, 8, width of each stored remainder and of each channel divider

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pulse_id_tick_i  in  1  one-cycle strobe: frame_tick & (payload_type == 8'h01)
- pulse_id_i  in  WIDTH  pulse ID carried in the frame; valid with the tick
- divider_i  in  N_CHANNELS*REM_WIDTH  per-channel divider; channel k is at [k*REM_WIDTH +: REM_WIDTH]
- enable_i  in  N_CHANNELS  per-channel enable (the status[0] bit of each channel)
- div_start_o  out  1  one-cycle start pulse to the divider
- div_a_o  out  WIDTH  dividend
- div_b_o  out  WIDTH  divisor, zero-extended
- div_done_i  in  1  divider completion, high for one cycle
- div_rem_i  in  WIDTH  divider remainder; valid with div_done_i
- rem_o  out  N_CHANNELS*REM_WIDTH  registered remainder per channel
- rem_valid_o  out  N_CHANNELS  one-cycle pulse per channel when rem_o[k] updates
- busy_o  out  1  a sequence is in progress
- overrun_o  out  1  sticky flag: a tick arrived while busy; cleared only by reset

Behaviour:
- Reset values:
  - rem_o = 0, rem_valid_o = 0, busy_o = 0, overrun_o = 0
  - div_start_o = 0, div_a_o = 0, div_b_o = 0
  - FSM = IDLE, pending = 0, channel index = 0
- Tick handling: on pulse_id_tick_i, register id_reg <= pulse_id_i + 1 (mod 2^WIDTH). The +1 is required because the result is consumed at the next pulse.
- Wrap-around: pulse_id_i = 2^WIDTH-1 gives id_reg = 0.
- FSM states:
  - IDLE: a tick latches id_reg, sets channel index k = 0 and goes to SELECT. busy_o is asserted from the cycle after the tick.
  - SELECT: evaluates channel k.
    - enable_i[k] = 0: skip the channel. rem_o[k] is held, no valid pulse.
    - divider[k] == 0: rem_o[k] <= 0 and rem_valid_o[k] pulses. No division is issued.
    - Otherwise: drive div_a_o = id_reg and div_b_o = divider[k], pulse div_start_o for one cycle, go to WAIT.
    - Each SELECT evaluation takes one cycle.
  - WAIT: div_a_o and div_b_o are held stable. On div_done_i, rem_o[k] <= div_rem_i[REM_WIDTH-1:0] and rem_valid_o[k] pulses the next cycle. Then go to NEXT.
  - NEXT: if k == N_CHANNELS-1, go to IDLE (or restart if pending is set, see below). Otherwise k <= k+1 and go to SELECT.
- Divider snapshot: divider_i is sampled at SELECT of each channel. A change during a division affects only channels not yet selected.
- Latency: with the tick at cycle T, the first div_start_o occurs at T+2 (T+1 is IDLE->SELECT). The total sequence takes the sum of the divider latencies plus 2 cycles per channel.
- Tick while busy:
  - Set overrun_o, latch the new id_reg and set pending.
  - An in-flight division is never aborted. Its result is still written to rem_o[k].
  - After that WAIT completes, the FSM restarts at k = 0 with the new id_reg and clears pending.
  - A tick in the same cycle as the final NEXT is treated as pending.
- The remainder fits REM_WIDTH because divider < 2^REM_WIDTH. The upper bits of div_rem_i are ignored.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. A subsequent div_done_i from the divider is ignored in IDLE.
- A spurious div_done_i outside WAIT is ignored.

Decomposition:
- Shared package: a REM_WIDTH constant, a sched_state_t enum (IDLE, SELECT, WAIT, NEXT), and a function that extracts channel k's divider from the packed vector.
- No sub-module. The existing LongDivision (WIDTH=64) is instantiated beside this block at board level and connected through the div_* ports.
- The bench uses a behavioural divider model with a configurable latency.

Test Plan:
- Basic sequence: N=4, dividers {3,5,7,10}, all enabled, pulse_id=99 -> remainders (100 mod d) = {1,0,2,0}. rem_valid pulses in channel order 0..3; busy_o deasserts after channel 3.
- Skip and zero divider: enable=4'b1011, divider[1]=0, divider[3]=4, pulse_id=6 -> ch1 rem=0 with valid pulse and no div_start; ch2 rem held at its previous value, no valid; ch3 rem=3 (7 mod 4).
- Wrap-around: pulse_id=64'hFFFF_FFFF_FFFF_FFFF, divider 7 -> div_a_o=0 and rem=0.
- Overrun: tick with id=10, second tick with id=20 during ch1's WAIT (divider latency 65 cycles) -> overrun_o=1; ch1 finishes with the result for 11; the sequence restarts with ch0 using 21.
- Reset mid-WAIT: assert reset, then drive div_done_i 5 cycles after release -> all outputs stay 0 and the FSM stays in IDLE; a new tick then sequences normally.
